// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional FETCH_ALIGN_CHK_EN adds the address-error flag to each queue entry.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FETCH_ALIGN_CHK_EN
    logic        adel;
`endif
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// In-order FIFO of fetched {pc, instr} entries; DEPTH must be a power of two.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  // Entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; clear wins over push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, imem credit/drop tracking, F-stage outputs.
// Define FETCH_ALIGN_CHK_EN to raise exc_adel_F on a misaligned fetch PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Stall_FD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_F,
  output logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PCplus4_F
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic        exc_adel_F
`endif
);

  localparam int CW = $clog2(QDEPTH+1);

  logic [31:0]  fetch_pc_r;
  logic [31:0]  resp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] count_s;
  logic [CW:0]  used_s;
  logic         pop_s;
  logic         push_s;
  logic         credit_ok_s;
  logic         fetch_ok_s;
  logic         adel_push_s;
  logic         imem_req_s;
  logic         accept_s;
  logic         live_rsp_s;
  fetch_entry_t push_data_s;
  fetch_entry_t head_s;

  // Queue credit: in-flight words (doomed or not) plus buffered words stay within QDEPTH
  always_comb begin
    pop_s       = valid_F & ~Stall_FD & ~redirect;
    used_s      = {1'b0, outstanding_r} + {1'b0, count_s} - {{CW{1'b0}}, pop_s};
    credit_ok_s = (used_s < (CW+1)'(QDEPTH));
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic adel_done_r;
  logic misalign_s;

  // Misaligned PC: stop issuing, emit one exception entry once the pipe is empty
  always_comb begin
    misalign_s  = (fetch_pc_r[1:0] != 2'b00);
    fetch_ok_s  = ~misalign_s;
    adel_push_s = reset & misalign_s & ~adel_done_r & (outstanding_r == '0)
                  & ~redirect & credit_ok_s;
  end

  // One exception entry per redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adel_done_r <= 1'b0;
    end else if (redirect) begin
      adel_done_r <= 1'b0;
    end else if (adel_push_s) begin
      adel_done_r <= 1'b1;
    end
  end
`else
  assign fetch_ok_s  = 1'b1;
  assign adel_push_s = 1'b0;
`endif

  // Request handshake and queue push selection
  always_comb begin
    imem_req_s        = reset & ~redirect & credit_ok_s & fetch_ok_s;
    accept_s          = imem_req_s & imem_ready;
    live_rsp_s        = imem_rvalid & (drop_r == '0) & ~redirect;
    push_data_s       = '0;
    push_data_s.pc    = resp_pc_r;
    push_data_s.instr = imem_rdata;
`ifdef FETCH_ALIGN_CHK_EN
    if (adel_push_s) begin
      push_data_s.pc    = fetch_pc_r;
      push_data_s.instr = NOP_INSTR;
      push_data_s.adel  = 1'b1;
    end else begin
      push_data_s.adel  = 1'b0;
    end
`endif
    push_s = live_rsp_s | adel_push_s;
  end

  // Fetch PC, PC of the oldest live response, credit and drop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc;
      resp_pc_r     <= redirect_pc;
      outstanding_r <= outstanding_r - CW'(imem_rvalid);
      drop_r        <= outstanding_r - CW'(imem_rvalid);
    end else begin
      if (accept_s) fetch_pc_r <= next_pc(fetch_pc_r);
      outstanding_r <= outstanding_r + CW'(accept_s) - CW'(imem_rvalid);
      if (imem_rvalid && (drop_r != '0)) drop_r <= drop_r - CW'(1);
      if (live_rsp_s) resp_pc_r <= next_pc(resp_pc_r);
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .clear     (redirect),
    .count     (count_s),
    .head      (head_s)
  );

  assign imem_req  = imem_req_s;
  assign imem_addr = fetch_pc_r;
  assign valid_F   = (count_s != '0) & ~redirect;
  assign instr_F   = valid_F ? head_s.instr : NOP_INSTR;
  assign PC_F      = valid_F ? head_s.pc : 32'h0000_0000;
  assign PCplus4_F = valid_F ? next_pc(head_s.pc) : 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
  assign exc_adel_F = valid_F & head_s.adel;
`endif

endmodule
